cpu_memory_access: RTL and testbench
====================================

# cpu_memory_access

Memory stage of the mox125 pipeline, directly downstream of the execute stage. Takes the registered execute results (addresses, store data, register write-back data and indices, pipeline control bits) and performs data loads and stores over a 16-bit big-endian Wishbone data port. 32-bit accesses are split into two 16-bit bus cycles. The merged result goes to the write-back stage, and the upstream pipeline is stalled while a bus access is outstanding.

## Interface
- PCB_WIDTH, 6, width of pipeline control bits; instantiate with `PCB_WIDTH.
- PCB_WA, 0, bit index of register-0 write enable; instantiate with `PCB_WA.
- PCB_WB, 1, bit index of register-1 write enable; instantiate with `PCB_WB.
- PCB_RM, 2, bit index of memory-read request; instantiate with `PCB_RM.
- PCB_WM, 3, bit index of memory-write request; instantiate with `PCB_WM.
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  reset; asynchronous, active-high.
- flush_i  in  1  discard the instruction presented this cycle.
- pipeline_control_bits_i  in  PCB_WIDTH  control bits from execute.
- register0_write_index_i, register1_write_index_i  in  4 each  write-back register indices.
- reg0_result_i, reg1_result_i  in  32 each  ALU/pointer results.
- memory_address_i  in  32  byte address of the access.
- mem_result_i  in  32  store data, right-justified.
- mem_size_i  in  2  access size: 00 = byte, 01 = short, 10 = long, 11 = treated as long.
- stall_o  out  1  hold upstream stages.
- dmem_address_o  out  32  Wishbone address; bit 0 is always 0.
- dmem_data_o  out  16  Wishbone write data.
- dmem_data_i  in  16  Wishbone read data.
- dmem_sel_o  out  2  byte lanes; [1] = even byte (data[15:8]), [0] = odd byte.
- dmem_we_o, dmem_stb_o, dmem_cyc_o  out  1 each  Wishbone controls.
- dmem_ack_i  in  1  Wishbone acknowledge.
- register_wea_o, register_web_o  out  1 each  write-back enables.
- register0_write_index_o, register1_write_index_o  out  4 each  write-back indices.
- reg0_result_o, reg1_result_o  out  32 each  write-back data.
- pipeline_control_bits_o  out  PCB_WIDTH  control bits forwarded to write-back.

## Operation
- State machine states:
  - IDLE: accepts a new instruction.
  - ACC0: first or only bus cycle.
  - ACC1: second half of a long.
  - DONE: one cycle to register the result and release the stall.
- Instruction accepted in IDLE when not flush_i:
  - If neither RM nor WM is set, it passes through to the outputs on the next edge and the state stays IDLE.
  - If RM or WM is set, latch all inputs and go to ACC0. cyc, stb and stall_o assert. we = WM.
- Bus address and lanes:
  - Long: ACC0 address = {addr[31:1],0}, sel = 11, write data = mem_result[31:16] (big-endian high half first). ACC1 address = ACC0 address + 2, sel = 11, write data = mem_result[15:0].
  - Short: sel = 11, write data = mem_result[15:0].
  - Byte: sel = 10 at an even address, 01 at an odd address. Write data = {b,b}, where b = mem_result[7:0].
- Load data:
  - Long: {hi, lo}.
  - Short: zero-extended 16 bits.
  - Byte: zero-extended selected lane.
  - The loaded data replaces reg0_result_o. reg1_result_o, the indices and the enables are passed unchanged.
- Transitions on an edge with ack high:
  - ACC0 → ACC1 for a long, otherwise ACC0 → DONE.
  - ACC1 → DONE.
  - With ack low, the state holds and all bus outputs hold.
- DONE: cyc/stb/we drop and stall_o drops. Outputs are registered on the edge leaving DONE. DONE → IDLE.
- flush_i:
  - In IDLE, the incoming instruction is dropped: register_wea_o, register_web_o and pipeline_control_bits_o go to 0 on the next edge.
  - During ACC0/ACC1/DONE it is ignored. An in-flight access belongs to an older instruction and always completes and writes back.
- Non-memory cycles and bubbles: write-back enables come from PCB_WA/PCB_WB of the accepted instruction. An idle cycle with no accepted instruction drives both enables and pipeline_control_bits_o to 0.

## Timing
- Reset (asynchronous, immediate): state = IDLE and all outputs 0: stall_o, cyc, stb, we, sel, address, data outputs, enables, indices, results, pipeline_control_bits_o.
- Reset mid-access: cyc/stb drop immediately and the access is abandoned.
- Pass-through latency: 1 cycle.
- Short/byte access: stall_o high from the edge after acceptance through the ack cycle plus DONE. With zero-wait ack, the result appears 3 edges after acceptance.
- Long access: one extra cycle per extra ack. stb stays continuously high between ACC0 and ACC1; only the address and data change.
- stall_o is registered, and upstream must hold its outputs while it is high. An instruction presented while stall_o is high is not accepted.
- Write-back outputs change only on pass-through or DONE edges and hold otherwise. After DONE, the enables are cleared unless a new instruction is accepted.

## Test plan
- Pass-through ALU op: WA=1, index 3, reg0 = 0x12345678 → next cycle wea = 1, index 3, reg0_result_o = 0x12345678, no cyc.
- Long store of 0xDEADBEEF to 0x1000, ack after 2 waits each → bus 0x1000/0xDEAD then 0x1002/0xBEEF, sel 11, we = 1, stall_o high throughout, wea = 0.
- Long load from 0x2000 returning 0xCAFE then 0xF00D, index 5 → reg0_result_o = 0xCAFEF00D, wea = 1, index 5.
- Byte load from 0x3001 returning 0x12AB → sel 01, address 0x3000, reg0_result_o = 0x000000AB. Byte store of 0x77 to 0x3000 → sel 10, data 0x7777.
- flush_i during a long load (ACC1) → load completes and writes back. flush_i in IDLE with WA=1 → wea stays 0.
- rst_i asserted while stb high waiting for ack → cyc/stb/stall_o drop the same cycle, state IDLE. The next accepted op executes normally.

Source files
------------

// File: rtl/cpu_memory_access_if.sv
// 16-bit big-endian Wishbone data port between the mox125 memory stage and data memory.
`ifndef PCB_WIDTH
`define PCB_WIDTH 6
`endif
`ifndef PCB_WA
`define PCB_WA 0
`endif
`ifndef PCB_WB
`define PCB_WB 1
`endif
`ifndef PCB_RM
`define PCB_RM 2
`endif
`ifndef PCB_WM
`define PCB_WM 3
`endif

// A bus cycle is open while cyc and stb are high. It completes on the clock edge where
// ack is high. Until then the master holds address, data, sel and we stable.
interface cpu_memory_access_if;
    logic [31:0] dmem_address_o;
    logic [15:0] dmem_data_o;
    logic [15:0] dmem_data_i;
    logic [1:0]  dmem_sel_o;
    logic        dmem_we_o;
    logic        dmem_stb_o;
    logic        dmem_cyc_o;
    logic        dmem_ack_i;

    modport master (
        output dmem_address_o, dmem_data_o, dmem_sel_o, dmem_we_o, dmem_stb_o, dmem_cyc_o,
        input  dmem_data_i, dmem_ack_i
    );

    modport slave (
        input  dmem_address_o, dmem_data_o, dmem_sel_o, dmem_we_o, dmem_stb_o, dmem_cyc_o,
        output dmem_data_i, dmem_ack_i
    );
endinterface

// File: rtl/cpu_memory_access.sv
// mox125 memory stage: loads/stores over a 16-bit big-endian Wishbone port, longs split in two.
`ifndef PCB_WIDTH
`define PCB_WIDTH 6
`endif
`ifndef PCB_WA
`define PCB_WA 0
`endif
`ifndef PCB_WB
`define PCB_WB 1
`endif
`ifndef PCB_RM
`define PCB_RM 2
`endif
`ifndef PCB_WM
`define PCB_WM 3
`endif

module cpu_memory_access #(
    parameter int PCB_WIDTH = `PCB_WIDTH,
    parameter int PCB_WA    = `PCB_WA,
    parameter int PCB_WB    = `PCB_WB,
    parameter int PCB_RM    = `PCB_RM,
    parameter int PCB_WM    = `PCB_WM
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic [PCB_WIDTH-1:0] pipeline_control_bits_i,
    input  logic [3:0]           register0_write_index_i,
    input  logic [3:0]           register1_write_index_i,
    input  logic [31:0]          reg0_result_i,
    input  logic [31:0]          reg1_result_i,
    input  logic [31:0]          memory_address_i,
    input  logic [31:0]          mem_result_i,
    input  logic [1:0]           mem_size_i,
    output logic                 stall_o,
    cpu_memory_access_if.master  dmem,
    output logic                 register_wea_o,
    output logic                 register_web_o,
    output logic [3:0]           register0_write_index_o,
    output logic [3:0]           register1_write_index_o,
    output logic [31:0]          reg0_result_o,
    output logic [31:0]          reg1_result_o,
    output logic [PCB_WIDTH-1:0] pipeline_control_bits_o,
    output logic [1:0]           state_o
);
    typedef enum logic [1:0] {IDLE = 2'd0, ACC0 = 2'd1, ACC1 = 2'd2, DONE = 2'd3} state_t;

    state_t               state_q, state_d;
    logic [1:0]           size_q, size_d;
    logic                 odd_q, odd_d;
    logic                 rd_q, rd_d;
    logic [15:0]          wlo_q, wlo_d;
    logic [31:0]          ld_q, ld_d;
    logic [PCB_WIDTH-1:0] pcb_q, pcb_d;
    logic [3:0]           idx0_q, idx0_d, idx1_q, idx1_d;
    logic [31:0]          reg0_q, reg0_d, reg1_q, reg1_d;
    logic                 stall_q, stall_d, bus_q, bus_d, we_q, we_d;
    logic [1:0]           sel_q, sel_d;
    logic [31:0]          dadr_q, dadr_d;
    logic [15:0]          ddat_q, ddat_d;
    logic                 wea_q, wea_d, web_q, web_d;
    logic [3:0]           oidx0_q, oidx0_d, oidx1_q, oidx1_d;
    logic [31:0]          ores0_q, ores0_d, ores1_q, ores1_d;
    logic [PCB_WIDTH-1:0] opcb_q, opcb_d;

    always_comb begin
        state_d = state_q;  size_d = size_q;   odd_d = odd_q;     rd_d = rd_q;
        wlo_d = wlo_q;      ld_d = ld_q;       pcb_d = pcb_q;     idx0_d = idx0_q;
        idx1_d = idx1_q;    reg0_d = reg0_q;   reg1_d = reg1_q;   stall_d = stall_q;
        bus_d = bus_q;      we_d = we_q;       sel_d = sel_q;     dadr_d = dadr_q;
        ddat_d = ddat_q;    wea_d = wea_q;     web_d = web_q;     oidx0_d = oidx0_q;
        oidx1_d = oidx1_q;  ores0_d = ores0_q; ores1_d = ores1_q; opcb_d = opcb_q;
        case (state_q)
            IDLE: begin
                if (flush_i) begin
                    wea_d  = 1'b0;
                    web_d  = 1'b0;
                    opcb_d = '0;
                end else if (pipeline_control_bits_i[PCB_RM] | pipeline_control_bits_i[PCB_WM]) begin
                    state_d = ACC0;
                    stall_d = 1'b1;
                    bus_d   = 1'b1;
                    we_d    = pipeline_control_bits_i[PCB_WM];
                    rd_d    = ~pipeline_control_bits_i[PCB_WM];
                    size_d  = mem_size_i;
                    odd_d   = memory_address_i[0];
                    wlo_d   = mem_result_i[15:0];
                    pcb_d   = pipeline_control_bits_i;
                    idx0_d  = register0_write_index_i;
                    idx1_d  = register1_write_index_i;
                    reg0_d  = reg0_result_i;
                    reg1_d  = reg1_result_i;
                    dadr_d  = {memory_address_i[31:1], 1'b0};
                    if (mem_size_i[1]) begin
                        sel_d  = 2'b11;
                        ddat_d = mem_result_i[31:16];
                    end else if (mem_size_i[0]) begin
                        sel_d  = 2'b11;
                        ddat_d = mem_result_i[15:0];
                    end else begin
                        sel_d  = memory_address_i[0] ? 2'b01 : 2'b10;
                        ddat_d = {2{mem_result_i[7:0]}};
                    end
                    // The write-back stage sees a bubble until this access completes.
                    wea_d  = 1'b0;
                    web_d  = 1'b0;
                    opcb_d = '0;
                end else begin
                    wea_d   = pipeline_control_bits_i[PCB_WA];
                    web_d   = pipeline_control_bits_i[PCB_WB];
                    opcb_d  = pipeline_control_bits_i;
                    oidx0_d = register0_write_index_i;
                    oidx1_d = register1_write_index_i;
                    ores0_d = reg0_result_i;
                    ores1_d = reg1_result_i;
                end
            end
            ACC0: begin
                if (dmem.dmem_ack_i) begin
                    if (size_q[1]) begin
                        state_d = ACC1;
                        dadr_d  = dadr_q + 32'd2;
                        ddat_d  = wlo_q;
                        ld_d    = {dmem.dmem_data_i, 16'h0000};
                    end else begin
                        state_d = DONE;
                        bus_d   = 1'b0;
                        we_d    = 1'b0;
                        if (size_q[0]) ld_d = {16'h0000, dmem.dmem_data_i};
                        else ld_d = {24'h000000, odd_q ? dmem.dmem_data_i[7:0] : dmem.dmem_data_i[15:8]};
                    end
                end
            end
            ACC1: begin
                if (dmem.dmem_ack_i) begin
                    state_d = DONE;
                    bus_d   = 1'b0;
                    we_d    = 1'b0;
                    ld_d    = {ld_q[31:16], dmem.dmem_data_i};
                end
            end
            DONE: begin
                state_d = IDLE;
                stall_d = 1'b0;
                wea_d   = pcb_q[PCB_WA];
                web_d   = pcb_q[PCB_WB];
                opcb_d  = pcb_q;
                oidx0_d = idx0_q;
                oidx1_d = idx1_q;
                ores0_d = rd_q ? ld_q : reg0_q;
                ores1_d = reg1_q;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;  size_q <= '0;  odd_q <= 1'b0;  rd_q <= 1'b0;
            wlo_q <= '0;      ld_q <= '0;    pcb_q <= '0;    idx0_q <= '0;
            idx1_q <= '0;     reg0_q <= '0;  reg1_q <= '0;   stall_q <= 1'b0;
            bus_q <= 1'b0;    we_q <= 1'b0;  sel_q <= '0;    dadr_q <= '0;
            ddat_q <= '0;     wea_q <= 1'b0; web_q <= 1'b0;  oidx0_q <= '0;
            oidx1_q <= '0;    ores0_q <= '0; ores1_q <= '0;  opcb_q <= '0;
        end else begin
            state_q <= state_d;  size_q <= size_d;   odd_q <= odd_d;     rd_q <= rd_d;
            wlo_q <= wlo_d;      ld_q <= ld_d;       pcb_q <= pcb_d;     idx0_q <= idx0_d;
            idx1_q <= idx1_d;    reg0_q <= reg0_d;   reg1_q <= reg1_d;   stall_q <= stall_d;
            bus_q <= bus_d;      we_q <= we_d;       sel_q <= sel_d;     dadr_q <= dadr_d;
            ddat_q <= ddat_d;    wea_q <= wea_d;     web_q <= web_d;     oidx0_q <= oidx0_d;
            oidx1_q <= oidx1_d;  ores0_q <= ores0_d; ores1_q <= ores1_d; opcb_q <= opcb_d;
        end
    end

    assign stall_o                 = stall_q;
    assign dmem.dmem_cyc_o         = bus_q;
    assign dmem.dmem_stb_o         = bus_q;
    assign dmem.dmem_we_o          = we_q;
    assign dmem.dmem_sel_o         = sel_q;
    assign dmem.dmem_address_o     = dadr_q;
    assign dmem.dmem_data_o        = ddat_q;
    assign register_wea_o          = wea_q;
    assign register_web_o          = web_q;
    assign register0_write_index_o = oidx0_q;
    assign register1_write_index_o = oidx1_q;
    assign reg0_result_o           = ores0_q;
    assign reg1_result_o           = ores1_q;
    assign pipeline_control_bits_o = opcb_q;
    assign state_o                 = state_q;
endmodule

// File: tb/tb_cpu_memory_access.sv
// Self-checking bench for cpu_memory_access: bus-slave scoreboard plus write-back scoreboard.
`ifndef PCB_WIDTH
`define PCB_WIDTH 6
`endif
`ifndef PCB_WA
`define PCB_WA 0
`endif
`ifndef PCB_WB
`define PCB_WB 1
`endif
`ifndef PCB_RM
`define PCB_RM 2
`endif
`ifndef PCB_WM
`define PCB_WM 3
`endif

module tb_cpu_memory_access;
  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic                  flush = 1'b0;
  logic [`PCB_WIDTH-1:0] pcb_i = '0;
  logic [3:0]            idx0_i = '0, idx1_i = '0;
  logic [31:0]           r0_i = '0, r1_i = '0, addr_i = '0, mres_i = '0;
  logic [1:0]            size_i = '0;
  logic                  stall_o, wea_o, web_o;
  logic [3:0]            idx0_o, idx1_o;
  logic [31:0]           r0_o, r1_o;
  logic [`PCB_WIDTH-1:0] pcb_o;
  logic [1:0]            state_o;

  cpu_memory_access_if dmem_if();

  cpu_memory_access dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .pipeline_control_bits_i(pcb_i),
    .register0_write_index_i(idx0_i), .register1_write_index_i(idx1_i),
    .reg0_result_i(r0_i), .reg1_result_i(r1_i),
    .memory_address_i(addr_i), .mem_result_i(mres_i), .mem_size_i(size_i),
    .stall_o(stall_o), .dmem(dmem_if),
    .register_wea_o(wea_o), .register_web_o(web_o),
    .register0_write_index_o(idx0_o), .register1_write_index_o(idx1_o),
    .reg0_result_o(r0_o), .reg1_result_o(r1_o),
    .pipeline_control_bits_o(pcb_o), .state_o(state_o)
  );

  int n_tests = 0;
  int n_fail = 0;
  int waits = 0;
  int wait_cnt = 0;
  logic [50:0] exp_bus_q[$];
  logic [15:0] rdata_q[$];
  logic [79:0] exp_q[$];
  logic [79:0] last_exp = '0;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [79:0] got_wb();
    return {wea_o, web_o, pcb_o, idx0_o, idx1_o, r0_o, r1_o};
  endfunction

  // bus slave and bus scoreboard: the beat is checked on the cycle it is acknowledged
  always @(negedge clk) begin
    logic [50:0] obs;
    logic [50:0] exp;
    if (rst) begin
      dmem_if.dmem_ack_i = 1'b0;
      dmem_if.dmem_data_i = 16'h0;
      wait_cnt = 0;
    end else begin
      dmem_if.dmem_ack_i = 1'b0;
      if (dmem_if.dmem_cyc_o && dmem_if.dmem_stb_o) begin
        if (wait_cnt >= waits) begin
          wait_cnt = 0;
          obs = {dmem_if.dmem_we_o, dmem_if.dmem_sel_o, dmem_if.dmem_address_o,
                 dmem_if.dmem_we_o ? dmem_if.dmem_data_o : 16'h0};
          if (exp_bus_q.size() == 0) begin
            check("bus_unexpected", {29'h0, obs}, 80'h0);
          end else begin
            exp = exp_bus_q.pop_front();
            check("bus_beat", {29'h0, obs}, {29'h0, exp});
          end
          check("bus_stall", {79'h0, stall_o}, 80'h1);
          check("bus_wb_en", {78'h0, wea_o, web_o}, 80'h0);
          if (!dmem_if.dmem_we_o) dmem_if.dmem_data_i = (rdata_q.size() != 0) ? rdata_q.pop_front() : 16'h0;
          dmem_if.dmem_ack_i = 1'b1;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // driver: present one instruction for one edge, then fall back to a bubble
  task automatic present(input logic [`PCB_WIDTH-1:0] p, input logic [3:0] i0, input logic [3:0] i1,
                         input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] ad,
                         input logic [31:0] mr, input logic [1:0] sz, input logic fl);
    pcb_i = p; idx0_i = i0; idx1_i = i1; r0_i = a0; r1_i = a1;
    addr_i = ad; mres_i = mr; size_i = sz; flush = fl;
    @(negedge clk);
    pcb_i = '0;
    flush = 1'b0;
  endtask

  task automatic run_op(input logic [`PCB_WIDTH-1:0] p, input logic [3:0] i0, input logic [3:0] i1,
                        input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] ad,
                        input logic [31:0] mr, input logic [1:0] sz, input int w,
                        input logic [15:0] rh, input logic [15:0] rl, input logic flush_acc1);
    logic rm, wm;
    logic [31:0] ae, ld;
    logic [7:0] b;
    logic [79:0] e;
    int words, lat, cyc_n;
    rm = p[`PCB_RM];
    wm = p[`PCB_WM];
    ae = {ad[31:1], 1'b0};
    b = mr[7:0];
    ld = a0;
    words = 0;
    waits = w;
    if (rm || wm) begin
      if (sz[1]) begin
        exp_bus_q.push_back({wm, 2'b11, ae, wm ? mr[31:16] : 16'h0});
        exp_bus_q.push_back({wm, 2'b11, ae + 32'd2, wm ? mr[15:0] : 16'h0});
        words = 2;
        if (!wm) begin rdata_q.push_back(rh); rdata_q.push_back(rl); ld = {rh, rl}; end
      end else if (sz[0]) begin
        exp_bus_q.push_back({wm, 2'b11, ae, wm ? mr[15:0] : 16'h0});
        words = 1;
        if (!wm) begin rdata_q.push_back(rh); ld = {16'h0, rh}; end
      end else begin
        exp_bus_q.push_back({wm, ad[0] ? 2'b01 : 2'b10, ae, wm ? {b, b} : 16'h0});
        words = 1;
        if (!wm) begin rdata_q.push_back(rh); ld = {24'h0, ad[0] ? rh[7:0] : rh[15:8]}; end
      end
      lat = 3 + words * w + words - 1;
    end else begin
      lat = 1;
    end
    exp_q.push_back({p[`PCB_WA], p[`PCB_WB], p, i0, i1, ld, a1});
    present(p, i0, i1, a0, a1, ad, mr, sz, 1'b0);
    cyc_n = 1;
    if (flush_acc1) begin
      while (state_o != 2'd2 && cyc_n < 300) begin @(negedge clk); cyc_n++; end
      pcb_i = 6'h01;
      flush = 1'b1;
      @(negedge clk);
      cyc_n++;
      pcb_i = '0;
      flush = 1'b0;
    end
    while (stall_o && cyc_n < 300) begin @(negedge clk); cyc_n++; end
    check("latency", {48'h0, 32'(cyc_n)}, {48'h0, 32'(lat)});
    e = exp_q.pop_front();
    last_exp = e;
    check("writeback", got_wb(), e);
    check("cyc_released", {79'h0, dmem_if.dmem_cyc_o}, 80'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [`PCB_WIDTH-1:0] p;
    logic [1:0] sz;
    int kind;
    @(negedge clk);
    check("reset_wb", got_wb(), 80'h0);
    check("reset_bus", {24'h0, dmem_if.dmem_cyc_o, dmem_if.dmem_stb_o, dmem_if.dmem_we_o,
          dmem_if.dmem_sel_o, dmem_if.dmem_address_o, dmem_if.dmem_data_o, stall_o, state_o}, 80'h0);
    rst = 1'b0;
    @(negedge clk);

    // pass-through ALU op
    run_op(6'h01, 4'd3, 4'd0, 32'h12345678, 32'h0, 32'h0, 32'h0, 2'b00, 0, 16'h0, 16'h0, 1'b0);
    // long store, two waits per beat
    run_op(6'h08, 4'd0, 4'd0, 32'h0, 32'h0, 32'h1000, 32'hDEADBEEF, 2'b10, 2, 16'h0, 16'h0, 1'b0);
    // long load
    run_op(6'h05, 4'd5, 4'd2, 32'h11111111, 32'h22222222, 32'h2000, 32'h0, 2'b10, 0, 16'hCAFE, 16'hF00D, 1'b0);
    // byte load odd lane, byte store even lane
    run_op(6'h05, 4'd7, 4'd0, 32'h0, 32'h0, 32'h3001, 32'h0, 2'b00, 0, 16'h12AB, 16'h0, 1'b0);
    run_op(6'h08, 4'd0, 4'd0, 32'h0, 32'h0, 32'h3000, 32'h00000077, 2'b00, 1, 16'h0, 16'h0, 1'b0);
    // byte load even lane, short load, size 11 store at odd address
    run_op(6'h07, 4'd8, 4'd9, 32'h0, 32'h55AA55AA, 32'h3100, 32'h0, 2'b00, 0, 16'h9A34, 16'h0, 1'b0);
    run_op(6'h05, 4'd4, 4'd0, 32'h0, 32'h0, 32'h3002, 32'h0, 2'b01, 0, 16'h8001, 16'h0, 1'b0);
    run_op(6'h38, 4'd0, 4'd0, 32'h0, 32'h0, 32'h5003, 32'h01020304, 2'b11, 1, 16'h0, 16'h0, 1'b0);
    // flush during the second half of a long load is ignored
    run_op(6'h05, 4'd6, 4'd0, 32'h0, 32'h0, 32'h6000, 32'h0, 2'b10, 1, 16'hA5A5, 16'h5A5A, 1'b1);

    // flush in IDLE: enables and control bits clear, indices and data hold
    run_op(6'h03, 4'd10, 4'd11, 32'hAAAA0000, 32'hBBBB0000, 32'h0, 32'h0, 2'b00, 0, 16'h0, 16'h0, 1'b0);
    present(6'h01, 4'd12, 4'd13, 32'hCCCC0000, 32'hDDDD0000, 32'h0, 32'h0, 2'b00, 1'b1);
    check("flush_idle", got_wb(), {8'h00, last_exp[71:0]});
    check("flush_idle_cyc", {79'h0, dmem_if.dmem_cyc_o}, 80'h0);

    // reset while the bus waits for ack
    waits = 1000;
    present(6'h05, 4'd6, 4'd0, 32'h0, 32'h0, 32'h4000, 32'h0, 2'b10, 1'b0);
    repeat (3) @(negedge clk);
    check("rst_pre_stb", {78'h0, dmem_if.dmem_stb_o, stall_o}, 80'h3);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bus", {76'h0, dmem_if.dmem_cyc_o, dmem_if.dmem_stb_o, stall_o, dmem_if.dmem_we_o}, 80'h0);
    check("rst_mid_state", {78'h0, state_o}, 80'h0);
    check("rst_mid_wb", got_wb(), 80'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_bus_q.delete();
    rdata_q.delete();
    run_op(6'h05, 4'd1, 4'd0, 32'h0, 32'h0, 32'h7002, 32'h0, 2'b01, 0, 16'h1357, 16'h0, 1'b0);

    // random mix
    for (int i = 0; i < 10; i++) begin
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      p = 6'($urandom_range(0, 63));
      if (kind == 0) p[3:2] = 2'b00;
      else if (kind == 1) p[3:2] = 2'b01;
      else p[3:2] = 2'b10;
      run_op(p, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom, $urandom,
             $urandom, $urandom, sz, $urandom_range(0, 2),
             16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)), 1'b0);
    end

    check("bus_leftover", {48'h0, 32'(exp_bus_q.size())}, 80'h0);
    check("rdata_leftover", {48'h0, 32'(rdata_q.size())}, 80'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
